// File: rtl/gpu_pkg.sv
// Shared types and sizing for the voxel_gpu back end.
//   pixel_write_t    : one shaded pixel as it travels through the writer FIFO
//   wr_state_e       : pixel writer bus FSM states
//   pixel_byte_addr  : base + zero-extended linear index, wrapping mod 2^32
package gpu;

  localparam int PIXEL_FIFO_DEPTH = 4;
  localparam int PIXEL_INDEX_W    = 17;

  typedef struct packed {
    logic [PIXEL_INDEX_W-1:0] index;
    logic [7:0]               colour;
  } pixel_write_t;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

  function automatic logic [31:0] pixel_byte_addr(input logic [31:0]              base,
                                                  input logic [PIXEL_INDEX_W-1:0] index);
    return base + 32'(index);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count.
// The head entry is presented on rdata whenever empty is low (show-ahead).
// Push is ignored while full and pop is ignored while empty, so callers may
// drive them unqualified. A pop while full does not free space for a push
// in the same cycle.
//   clock, reset : system clock, synchronous active-high reset
//   push, wdata  : write strobe and data
//   pop, rdata   : read strobe and head-of-queue data
//   full, empty  : registered status flags
//   count        : current number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/pixel_writer.sv
// Final voxel_gpu stage: queues shaded pixels and drains them as single-byte
// Avalon-MM writes to pixel_buffer + index. idle goes high only once the
// queue is empty and the last write has been accepted by the fabric.
//   clock, reset          : system clock, synchronous active-high reset
//   start, pixel_buffer   : frame start pulse and buffer base (honoured when idle)
//   in_valid/in_ready     : pixel handshake, in_index/in_colour payload
//   m_address/m_write/
//   m_writedata/
//   m_waitrequest         : Avalon-MM write master
//   idle                  : nothing queued or in flight
//   written_count         : writes accepted since the last honoured start
//
// state    | meaning
// WR_IDLE  | no write on the bus; pop the queue head when one arrives
// WR_WRITE | m_write held; on accept pop the next pixel or return to WR_IDLE
module pixel_writer
  import gpu::*;
#(
  parameter int INDEX_W    = PIXEL_INDEX_W,   // must match pixel_write_t.index
  parameter int FIFO_DEPTH = PIXEL_FIFO_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        pixel_buffer,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INDEX_W-1:0] in_index,
  input  logic [7:0]         in_colour,
  output logic [31:0]        m_address,
  output logic               m_write,
  output logic [7:0]         m_writedata,
  input  logic               m_waitrequest,
  output logic               idle,
  output logic [31:0]        written_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  wr_state_e     state_q;
  logic [31:0]   base_q;
  logic [31:0]   m_address_q;
  logic          m_write_q;
  logic [7:0]    m_writedata_q;
  logic [31:0]   written_count_q;
  logic          idle_q, idle_d;

  pixel_write_t  fifo_wdata, fifo_head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, fifo_count_nxt;
  logic          start_ok, state_idle_nxt;

  assign fifo_wdata.index  = in_index;
  assign fifo_wdata.colour = in_colour;

  // Ready comes from the registered full flag only, never from m_waitrequest
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  // Pop whenever the output register is free or is being freed this edge
  assign fifo_pop  = !fifo_empty && ((state_q == WR_IDLE) || !m_waitrequest);

  assign start_ok  = start && idle_q;

  // Look ahead one edge so idle is registered yet exact
  always_comb begin
    state_idle_nxt = fifo_empty && ((state_q == WR_IDLE) || !m_waitrequest);
    fifo_count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    idle_d         = state_idle_nxt && (fifo_count_nxt == '0);
  end

  sync_fifo #(
    .WIDTH ($bits(pixel_write_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= WR_IDLE;
      base_q          <= '0;
      m_address_q     <= '0;
      m_write_q       <= 1'b0;
      m_writedata_q   <= '0;
      written_count_q <= '0;
      idle_q          <= 1'b1;
    end else begin
      idle_q <= idle_d;
      // idle_q high implies an empty queue, so a new base can never race a pop
      if (start_ok) begin
        base_q          <= pixel_buffer;
        written_count_q <= '0;
      end
      unique case (state_q)
        WR_IDLE: begin
          if (!fifo_empty) begin
            m_address_q   <= pixel_byte_addr(base_q, fifo_head.index);
            m_writedata_q <= fifo_head.colour;
            m_write_q     <= 1'b1;
            state_q       <= WR_WRITE;
          end
        end
        WR_WRITE: begin
          if (!m_waitrequest) begin
            written_count_q <= written_count_q + 32'd1;
            if (!fifo_empty) begin
              m_address_q   <= pixel_byte_addr(base_q, fifo_head.index);
              m_writedata_q <= fifo_head.colour;
            end else begin
              m_write_q <= 1'b0;
              state_q   <= WR_IDLE;
            end
          end
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  assign m_address     = m_address_q;
  assign m_write       = m_write_q;
  assign m_writedata   = m_writedata_q;
  assign written_count = written_count_q;
  assign idle          = idle_q;

endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pixel_buffer;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_index;
  logic [7:0]  in_colour;
  logic [31:0] m_address;
  logic        m_write;
  logic [7:0]  m_writedata;
  logic        m_waitrequest;
  logic        idle;
  logic [31:0] written_count;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          wc_q [$];

  pixel_writer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .pixel_buffer  (pixel_buffer),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_index      (in_index),
    .in_colour     (in_colour),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .idle          (idle),
    .written_count (written_count)
  );

  always #5 clock = ~clock;

  // Accepted-write log: every edge where the fabric takes a write
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && m_write && !m_waitrequest) begin
      wa_q.push_back(m_address);
      wd_q.push_back(m_writedata);
      wc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic drive_px(input logic [16:0] idx, input logic [7:0] col);
    in_valid  = 1'b1;
    in_index  = idx;
    in_colour = col;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (!(idle && !m_write) && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    if (n >= max_cyc) chk("idle_timeout", 32'(idle), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pixel_buffer = '0;
    in_valid = 1'b0; in_index = '0; in_colour = '0; m_waitrequest = 1'b0;
    repeat (2) @(negedge clock);

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_m_write",  32'(m_write), 32'd0);
    chk("rst_m_addr",   m_address, 32'h0);
    chk("rst_m_data",   32'(m_writedata), 32'h0);
    chk("rst_idle",     32'(idle), 32'd1);
    chk("rst_count",    written_count, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // single pixel, zero wait; push in the same cycle as start
    clear_log();
    start = 1'b1; pixel_buffer = 32'h0800_0000;
    drive_px(17'd5, 8'h01);
    @(negedge clock);
    start = 1'b0; in_valid = 1'b0;
    chk("t1_latency_m_write", 32'(m_write), 32'd0);
    @(negedge clock);
    chk("t1_m_write", 32'(m_write), 32'd1);
    chk("t1_addr",    m_address, 32'h0800_0005);
    chk("t1_data",    32'(m_writedata), 32'h01);
    @(negedge clock);
    chk("t1_m_write_drop", 32'(m_write), 32'd0);
    chk("t1_count",        written_count, 32'd1);
    chk("t1_idle",         32'(idle), 32'd1);
    chk("t1_nwrites",      32'(wa_q.size()), 32'd1);

    // stall hold: address/data stable for 4 cycles, one write counted
    clear_log();
    m_waitrequest = 1'b1;
    drive_px(17'd76799, 8'hAB);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_write", 32'(m_write), 32'd1);
      chk("t2_hold_addr",  m_address, 32'h0801_2BFF);
      chk("t2_hold_data",  32'(m_writedata), 32'hAB);
      if (i == 3) m_waitrequest = 1'b0;
      @(negedge clock);
    end
    chk("t2_m_write_drop", 32'(m_write), 32'd0);
    chk("t2_count",        written_count, 32'd2);
    chk("t2_nwrites",      32'(wa_q.size()), 32'd1);

    // backpressure: 5 held (4 queued + 1 output), sixth must wait
    clear_log();
    m_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_px(17'(i), 8'h10 + 8'(i));
      chk("t3_ready_open", 32'(in_ready), 32'd1);
      @(negedge clock);
    end
    drive_px(17'd5, 8'h15);
    for (int i = 0; i < 3; i++) begin
      chk("t3_ready_full", 32'(in_ready), 32'd0);
      chk("t3_stall_addr", m_address, 32'h0800_0000);
      @(negedge clock);
    end
    chk("t3_count_stalled", written_count, 32'd2);
    m_waitrequest = 1'b0;
    begin
      int n = 0;
      while (!in_ready && n < 10) begin
        @(negedge clock);
        n++;
      end
      if (n >= 10) chk("t3_ready_timeout", 32'(in_ready), 32'd1);
    end
    @(negedge clock);
    in_valid = 1'b0;
    wait_idle(50);
    chk("t3_nwrites", 32'(wa_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
      chk("t3_order_addr", wa_q[i], 32'h0800_0000 + 32'(i));
      chk("t3_order_data", 32'(wd_q[i]), 32'h10 + 32'(i));
    end
    chk("t3_count", written_count, 32'd8);

    // throughput: restart count, fill, release, one accept per cycle
    start = 1'b1; pixel_buffer = 32'h0800_0000;
    @(negedge clock);
    start = 1'b0;
    chk("t4_count_cleared", written_count, 32'd0);
    clear_log();
    m_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_px(17'd10 + 17'(i), 8'h40 + 8'(i));
      @(negedge clock);
    end
    in_valid = 1'b0;
    m_waitrequest = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("t4_count_step", written_count, 32'(k));
    end
    chk("t4_m_write_drop", 32'(m_write), 32'd0);
    chk("t4_nwrites", 32'(wa_q.size()), 32'd5);
    for (int k = 1; k < 5 && k < wc_q.size(); k++)
      chk("t4_b2b_cycle", 32'(wc_q[k] - wc_q[k-1]), 32'd1);
    if (wa_q.size() == 5) chk("t4_last_addr", wa_q[4], 32'h0800_000E);

    // start while busy is ignored
    m_waitrequest = 1'b1;
    drive_px(17'd7, 8'h77);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t5_m_write", 32'(m_write), 32'd1);
    start = 1'b1; pixel_buffer = 32'h0900_0000;
    @(negedge clock);
    start = 1'b0;
    chk("t5_count_kept", written_count, 32'd5);
    chk("t5_addr_kept",  m_address, 32'h0800_0007);
    chk("t5_not_idle",   32'(idle), 32'd0);
    m_waitrequest = 1'b0;
    wait_idle(20);
    chk("t5_count_after", written_count, 32'd6);
    clear_log();
    drive_px(17'd8, 8'h88);
    @(negedge clock);
    in_valid = 1'b0;
    wait_idle(20);
    chk("t5_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) chk("t5_base_kept", wa_q[0], 32'h0800_0008);
    chk("t5_count_final", written_count, 32'd7);

    // reset during a stalled write with 3 queued pixels
    m_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_px(17'd20 + 17'(i), 8'h60 + 8'(i));
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("t6_stalled_write", 32'(m_write), 32'd1);
    chk("t6_queue_ready",   32'(in_ready), 32'd1);
    clear_log();
    reset = 1'b1;
    @(negedge clock);
    chk("t6_m_write",  32'(m_write), 32'd0);
    chk("t6_idle",     32'(idle), 32'd1);
    chk("t6_count",    written_count, 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    m_waitrequest = 1'b0;
    repeat (10) @(negedge clock);
    chk("t6_no_writes",   32'(wa_q.size()), 32'd0);
    chk("t6_m_write_low", 32'(m_write), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
